csrhpm: RTL and testbench

Machine-mode hardware performance monitor block. It provides a parametrised bank of programmable counters, `mhpmcounter3..` with matching `mhpmevent3..` selectors, with:
- event selection and per-privilege-mode count filtering (Sscofpmf `MINH/SINH/UINH`);
- overflow flags and a local counter-overflow interrupt (LCOFI) request.

It sits beside the machine CSR file in the privileged unit. It shares the M-stage CSR write bus and `MCOUNTINHIBIT_REGW`, and its read value is ORed into the CSR read mux.

---
 rtl/csrhpm.sv | 148 ++++++++++++++
 tb/tb_csrhpm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/csrhpm.sv
// Machine-mode HPM counter bank: event select, privilege filtering, overflow flags and LCOFI pulse.
// Reads are combinational; state and LCOFIReqM update one cycle after the write or event.
module csrhpm #(
   parameter int XLEN         = 64,
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 16,
   parameter int COUNTER_BITS = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  CSRMWriteM,
   input  logic [11:0]           CSRAdrM,
   input  logic [XLEN-1:0]       CSRWriteValM,
   input  logic [31:0]           MCOUNTINHIBIT_REGW,
   input  logic [1:0]            PrivilegeModeM,
   input  logic [NUM_EVENTS-1:0] EventsM,
   output logic [XLEN-1:0]       CSRHPMReadValM,
   output logic                  CSRHPMHitM,
   output logic                  IllegalCSRHPMAccessM,
   output logic                  LCOFIReqM,
   output logic [31:0]           HPMOF_REGW
);
   localparam int         NC   = NUM_COUNTERS;
   localparam bit         RV64 = (XLEN == 64);
   localparam logic [8:0] NEV  = 9'(NUM_EVENTS);

   logic [COUNTER_BITS-1:0] cnt_q   [NC];
   logic [COUNTER_BITS-1:0] cnt_d   [NC];
   logic [7:0]              evsel_q [NC];
   logic [7:0]              evsel_d [NC];
   logic [NC-1:0]           of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
   logic                    lcofi_q, lcofi_d;

   logic        is_cnt, is_cnth, is_evt, is_evth, hi_acc, idx_ok;
   logic [4:0]  idx;
   logic [63:0] wdat, rd_full, cur, evr;
   logic [255:0] ev_all;
   logic        en, wr, mode_ok, wrap;
   logic [31:0] hpmof;

   assign idx     = CSRAdrM[4:0];
   assign idx_ok  = (idx >= 5'd3);
   assign is_cnt  = (CSRAdrM[11:5] == 7'h58);
   assign is_cnth = (CSRAdrM[11:5] == 7'h5C);
   assign is_evt  = (CSRAdrM[11:5] == 7'h19);
   assign is_evth = (CSRAdrM[11:5] == 7'h39);
   assign hi_acc  = is_cnth | is_evth;
   assign wdat    = 64'(CSRWriteValM);
   assign ev_all  = 256'(EventsM);

   assign CSRHPMHitM           = idx_ok & (is_cnt | is_cnth | is_evt | is_evth);
   assign IllegalCSRHPMAccessM = idx_ok & hi_acc & RV64;

   always_comb begin
      rd_full = '0;
      lcofi_d = 1'b0;
      hpmof   = '0;
      cur     = '0;
      evr     = '0;
      en      = 1'b0;
      wr      = 1'b0;
      mode_ok = 1'b0;
      wrap    = 1'b0;
      of_d    = of_q;
      minh_d  = minh_q;
      sinh_d  = sinh_q;
      uinh_d  = uinh_q;
      for (int k = 0; k < NC; k++) begin
         cnt_d[k]   = cnt_q[k];
         evsel_d[k] = evsel_q[k];
         cur = 64'(cnt_q[k]);
         evr = {of_q[k], minh_q[k], sinh_q[k], uinh_q[k], 52'd0, evsel_q[k]};
         if (idx == 5'(k + 3))
            rd_full = (is_cnt | is_cnth) ? cur : evr;

         case (PrivilegeModeM)
            2'b11:   mode_ok = ~minh_q[k];
            2'b01:   mode_ok = ~sinh_q[k];
            2'b00:   mode_ok = ~uinh_q[k];
            default: mode_ok = 1'b0;
         endcase
         en = (evsel_q[k] != 8'd0) & ev_all[evsel_q[k]] &
              ~MCOUNTINHIBIT_REGW[5'(k + 3)] & mode_ok;
         wr = CSRMWriteM & (idx == 5'(k + 3)) & ~(hi_acc & RV64);

         // A counter write of either half takes priority over that cycle's increment.
         wrap = 1'b0;
         if (wr & is_cnt)
            cnt_d[k] = RV64 ? COUNTER_BITS'(wdat) : COUNTER_BITS'({cur[63:32], wdat[31:0]});
         else if (wr & is_cnth & ~RV64)
            cnt_d[k] = COUNTER_BITS'({wdat[31:0], cur[31:0]});
         else if (en) begin
            cnt_d[k] = cnt_q[k] + COUNTER_BITS'(1);
            wrap     = &cnt_q[k];
         end
         of_d[k] = of_q[k] | wrap;
         lcofi_d = lcofi_d | (wrap & ~of_q[k]);

         // Event-register writes override the wrap-set OF; the pulse above used the old OF.
         if (wr & is_evt) begin
            evsel_d[k] = (9'(wdat[7:0]) < NEV) ? wdat[7:0] : 8'd0;
            if (RV64)
               {of_d[k], minh_d[k], sinh_d[k], uinh_d[k]} = wdat[63:60];
         end
         if (wr & is_evth & ~RV64)
            {of_d[k], minh_d[k], sinh_d[k], uinh_d[k]} = wdat[31:28];

         hpmof[5'(k + 3)] = of_q[k];
      end
   end

   always_comb begin
      CSRHPMReadValM = '0;
      if (CSRHPMHitM) begin
         if (hi_acc)
            CSRHPMReadValM = RV64 ? '0 : XLEN'(rd_full[63:32]);
         else
            CSRHPMReadValM = XLEN'(rd_full);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NC; k++) begin
            cnt_q[k]   <= '0;
            evsel_q[k] <= '0;
         end
         of_q    <= '0;
         minh_q  <= '0;
         sinh_q  <= '0;
         uinh_q  <= '0;
         lcofi_q <= 1'b0;
      end else begin
         for (int k = 0; k < NC; k++) begin
            cnt_q[k]   <= cnt_d[k];
            evsel_q[k] <= evsel_d[k];
         end
         of_q    <= of_d;
         minh_q  <= minh_d;
         sinh_q  <= sinh_d;
         uinh_q  <= uinh_d;
         lcofi_q <= lcofi_d;
      end
   end

   assign LCOFIReqM  = lcofi_q;
   assign HPMOF_REGW = hpmof;
endmodule

// File: tb/tb_csrhpm.sv
// Directed checks of csrhpm in an RV64/64-bit-counter and an RV32/40-bit-counter configuration.
module tb_csrhpm;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inh = '0;
   logic [1:0]  prv = 2'b11;

   logic        we64 = 1'b0, we32 = 1'b0;
   logic [11:0] a64 = '0, a32 = '0;
   logic [63:0] d64 = '0;
   logic [31:0] d32 = '0;
   logic [15:0] ev64 = '0, ev32 = '0;
   logic [63:0] rd64;
   logic [31:0] rd32;
   logic        hit64, ill64, lc64, hit32, ill32, lc32;
   logic [31:0] of64, of32;

   int total = 0, bad = 0, np64 = 0, np32 = 0, p0;
   logic [63:0] v;

   always #5 clk = ~clk;

   csrhpm #(.XLEN(64), .NUM_COUNTERS(4), .NUM_EVENTS(16), .COUNTER_BITS(64)) u64 (
      .clk(clk), .reset(reset), .CSRMWriteM(we64), .CSRAdrM(a64), .CSRWriteValM(d64),
      .MCOUNTINHIBIT_REGW(inh), .PrivilegeModeM(prv), .EventsM(ev64),
      .CSRHPMReadValM(rd64), .CSRHPMHitM(hit64), .IllegalCSRHPMAccessM(ill64),
      .LCOFIReqM(lc64), .HPMOF_REGW(of64));

   csrhpm #(.XLEN(32), .NUM_COUNTERS(4), .NUM_EVENTS(16), .COUNTER_BITS(40)) u32 (
      .clk(clk), .reset(reset), .CSRMWriteM(we32), .CSRAdrM(a32), .CSRWriteValM(d32),
      .MCOUNTINHIBIT_REGW(inh), .PrivilegeModeM(prv), .EventsM(ev32),
      .CSRHPMReadValM(rd32), .CSRHPMHitM(hit32), .IllegalCSRHPMAccessM(ill32),
      .LCOFIReqM(lc32), .HPMOF_REGW(of32));

   always @(negedge clk) begin
      if (lc64) np64++;
      if (lc32) np32++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic w64(input logic [11:0] a, input logic [63:0] d);
      a64 = a; d64 = d; we64 = 1'b1;
      @(posedge clk); #1;
      we64 = 1'b0;
   endtask

   task automatic r64(input logic [11:0] a, output logic [63:0] r);
      a64 = a; #1; r = rd64;
   endtask

   task automatic e64(input logic [15:0] e, input int n);
      ev64 = e;
      repeat (n) @(posedge clk);
      #1 ev64 = '0;
   endtask

   task automatic w32(input logic [11:0] a, input logic [31:0] d);
      a32 = a; d32 = d; we32 = 1'b1;
      @(posedge clk); #1;
      we32 = 1'b0;
   endtask

   task automatic r32(input logic [11:0] a, output logic [63:0] r);
      a32 = a; #1; r = 64'(rd32);
   endtask

   initial begin
      a64 = 12'hB03;
      #13;
      chk("rst_cnt3", 64'(rd64), 64'd0);
      chk("rst_hit", 64'(hit64), 64'd1);
      chk("rst_lcofi", 64'(lc64), 64'd0);
      chk("rst_of", 64'(of64), 64'd0);
      #10 reset = 1'b0;
      @(posedge clk); #1;

      // basic count
      w64(12'h323, 64'd5);
      e64(16'h0020, 10);
      r64(12'hB03, v); chk("cnt3_10", v, 64'd10);
      r64(12'hB04, v); chk("cnt4_idle", v, 64'd0);
      r64(12'h323, v); chk("evt3_rd", v, 64'd5);

      // privilege filter: MINH blocks M, U counts, mode 10 never counts, S counts
      w64(12'h324, 64'h4000_0000_0000_0002);
      prv = 2'b11; e64(16'h0004, 4);
      prv = 2'b00; e64(16'h0004, 4);
      r64(12'hB04, v); chk("minh_filter", v, 64'd4);
      prv = 2'b10; e64(16'h0004, 2);
      r64(12'hB04, v); chk("mode10", v, 64'd4);
      prv = 2'b01; e64(16'h0004, 2);
      r64(12'hB04, v); chk("smode", v, 64'd6);
      prv = 2'b11;

      // overflow and LCOFI
      w64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
      p0 = np64;
      e64(16'h0020, 2);
      repeat (3) @(posedge clk); #1;
      r64(12'hB03, v); chk("wrap_cnt", v, 64'd0);
      r64(12'h323, v); chk("wrap_of", v, 64'h8000_0000_0000_0005);
      chk("hpmof3", 64'(of64[3]), 64'd1);
      chk("lcofi_once", 64'(np64 - p0), 64'd1);
      w64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      p0 = np64;
      e64(16'h0020, 1);
      repeat (3) @(posedge clk); #1;
      chk("no_pulse_of_set", 64'(np64 - p0), 64'd0);

      // writing all-ones does not set OF
      w64(12'h323, 64'd5);
      w64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      r64(12'h323, v); chk("wr_ones_no_of", v, 64'd5);

      // collision: write beats increment, including a would-be wrap
      p0 = np64;
      a64 = 12'hB03; d64 = 64'd100; we64 = 1'b1; ev64 = 16'h0020;
      @(posedge clk); #1;
      we64 = 1'b0; ev64 = '0;
      r64(12'hB03, v); chk("collide_wr", v, 64'd100);
      e64(16'h0020, 1);
      r64(12'hB03, v); chk("collide_inc", v, 64'd101);
      repeat (2) @(posedge clk); #1;
      chk("collide_no_pulse", 64'(np64 - p0), 64'd0);

      // inhibit and legalisation
      inh = 32'h0000_0008;
      e64(16'h0020, 3);
      r64(12'hB03, v); chk("inhibit", v, 64'd101);
      inh = '0;
      w64(12'h323, 64'd16);
      r64(12'h323, v); chk("evsel_illegal", v, 64'd0);
      w64(12'h323, 64'd15);
      r64(12'h323, v); chk("evsel_max", v, 64'd15);

      // event write wins for OF, pulse still from old OF
      w64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      p0 = np64;
      a64 = 12'h323; d64 = 64'd5; we64 = 1'b1; ev64 = 16'h8000;
      @(posedge clk); #1;
      we64 = 1'b0; ev64 = '0;
      repeat (2) @(posedge clk); #1;
      r64(12'h323, v); chk("evtwr_of_wins", v, 64'd5);
      r64(12'hB03, v); chk("evtwr_cnt", v, 64'd0);
      chk("evtwr_pulse", 64'(np64 - p0), 64'd1);

      // decode boundaries
      a64 = 12'hB83; #1;
      chk("ill64_b83", 64'(ill64), 64'd1);
      chk("hit64_b83", 64'(hit64), 64'd1);
      chk("rd64_b83", rd64, 64'd0);
      a64 = 12'hB02; #1; chk("hit64_b02", 64'(hit64), 64'd0);
      w64(12'hB07, 64'd77);
      r64(12'hB07, v); chk("unimpl_rd", v, 64'd0);
      chk("unimpl_hit", 64'(hit64), 64'd1);
      chk("unimpl_legal", 64'(ill64), 64'd0);

      // RV32, 40-bit counters
      w32(12'hB83, 32'hFFFF_FFFF);
      r32(12'hB83, v); chk("rv32_hi_trunc", v, 64'h0000_00FF);
      chk("rv32_hi_legal", 64'(ill32), 64'd0);
      w32(12'h323, 32'd5);
      w32(12'hB03, 32'hFFFF_FFFF);
      p0 = np32;
      a32 = 12'hB03; ev32 = 16'h0020;
      @(posedge clk); #1;
      ev32 = '0;
      repeat (2) @(posedge clk); #1;
      r32(12'hB03, v); chk("rv32_wrap_lo", v, 64'd0);
      r32(12'hB83, v); chk("rv32_wrap_hi", v, 64'd0);
      r32(12'h723, v); chk("rv32_evth_of", v, 64'h8000_0000);
      chk("rv32_pulse", 64'(np32 - p0), 64'd1);
      w32(12'h723, 32'h4000_0000);
      r32(12'h723, v); chk("rv32_evth_wr", v, 64'h4000_0000);
      chk("rv32_of_clr", 64'(of32), 64'd0);
      w32(12'hB83, 32'h12);
      w32(12'hB03, 32'h34);
      r32(12'hB83, v); chk("rv32_hi_held", v, 64'h12);
      r32(12'hB03, v); chk("rv32_lo_wr", v, 64'h34);

      // async reset mid-count
      ev64 = 16'h8000;
      @(posedge clk); #3;
      reset = 1'b1; #1;
      a64 = 12'hB03; #1;
      chk("async_rst_cnt", rd64, 64'd0);
      chk("async_rst_lcofi", 64'(lc64), 64'd0);
      ev64 = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
